serial_divider: RTL and testbench

- Iterative restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Produces one quotient bit per clock and uses the same start/ready/stall handshake as serial_multiplier.
- Sits next to serial_multiplier in the execute stage. It holds the pipeline through stall while an operation is in flight.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/serial_divider_if.sv | 30 +++
 rtl/div_step.sv | 22 ++
 rtl/serial_divider.sv | 143 ++++++++++++++
 tb/tb_serial_divider.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// funct3 codes, divider state encoding and special-case constants.
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Unlisted codes fall back to DIVU: unsigned, quotient.
  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Request/response bundle between execute stage and divider.
// master = requester, slave = divider.
interface serial_divider_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
  logic             stall;
  logic             busy;
  logic [CNT_W-1:0] count_out;

  modport master (
    output start, funct3, A, B,
    input  result, quotient, remainder,
    input  ready, stall, busy, count_out
  );

  modport slave (
    input  start, funct3, A, B,
    output result, quotient, remainder,
    output ready, stall, busy, count_out
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted  = {rem, msb};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0]
                          : shifted[WIDTH-1:0];

endmodule

// File: rtl/serial_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU,
// one quotient bit per clock, stalls the pipe while running.
module serial_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] Q_DIV0 = '1;
  localparam logic [WIDTH-1:0] MIN_W =
    {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             is_rem_q;

  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] res_r;
  logic             rdy_r;

  logic             op_signed;
  logic             op_rem;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div0;
  logic             ovf;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign op_signed = f3_signed(bus.funct3);
  assign op_rem    = f3_rem(bus.funct3);
  assign a_neg     = op_signed & bus.A[WIDTH-1];
  assign b_neg     = op_signed & bus.B[WIDTH-1];
  assign a_mag     = a_neg ? -bus.A : bus.A;
  assign b_mag     = b_neg ? -bus.B : bus.B;
  assign div0      = (bus.B == '0);
  assign ovf       = op_signed
                   & (bus.A == MIN_W)
                   & (bus.B == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .msb      (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Remainder follows the dividend's sign.
  assign q_fix = neg_q_q ? -dvd_q : dvd_q;
  assign r_fix = neg_r_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      quo_r    <= '0;
      rem_r    <= '0;
      res_r    <= '0;
      rdy_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_q    <= a_mag;
            dvs_q    <= b_mag;
            rem_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            is_rem_q <= op_rem;
            if (div0) begin
              quo_r <= Q_DIV0;
              rem_r <= bus.A;
              res_r <= op_rem ? bus.A : Q_DIV0;
              rdy_r <= 1'b1;
              state <= DONE;
            end else if (ovf) begin
              quo_r <= MIN_W;
              rem_r <= '0;
              res_r <= op_rem ? '0 : MIN_W;
              rdy_r <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          quo_r <= q_fix;
          rem_r <= r_fix;
          res_r <= is_rem_q ? r_fix : q_fix;
          rdy_r <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          rdy_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result    = res_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.ready     = rdy_r;
  assign bus.count_out = cnt_q;
  assign bus.busy      = (state == CALC) || (state == FIX);
  assign bus.stall     = (state == IDLE && bus.start)
                       || (state == CALC)
                       || (state == FIX);

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider: results, latency,
// stall length, ignored restarts and async reset.
module tb_serial_divider;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_divider_if #(.WIDTH(32)) bus ();

  serial_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] q, r, res;
  int edges, stalls, pulses;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Starts one op, returns edges-to-ready (E0 counts as 1)
  // and the number of cycles stall was high.
  task automatic run_op(input logic [2:0]  f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int          poke);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.A      = a;
    bus.B      = b;
    edges  = 0;
    stalls = 0;
    q = '0; r = '0; res = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      @(posedge clk);
      #1;
      if (k == 0) bus.start = 1'b0;
      if (k == poke) begin
        bus.start  = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.A      = 32'd999;
        bus.B      = 32'd7;
      end
      if (k == poke + 1) bus.start = 1'b0;
      if (bus.ready) begin
        edges = k + 1;
        q     = bus.quotient;
        r     = bus.remainder;
        res   = bus.result;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("rdy_width", 32'(bus.ready), 32'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.A      = '0;
    bus.B      = '0;

    #12;
    check("rst_res", bus.result, 32'd0);
    check("rst_quo", bus.quotient, 32'd0);
    check("rst_rem", bus.remainder, 32'd0);
    check("rst_rdy", 32'(bus.ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(bus.count_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(F3_DIV, 32'd20, 32'd3, -1);
    check("div20_3_q", q, 32'd6);
    check("div20_3_r", r, 32'd2);
    check("div20_3_res", res, 32'd6);
    check("div20_3_lat", 32'(edges), 32'd34);
    check("div20_3_stall", 32'(stalls), 32'd34);

    run_op(F3_DIV, 32'hFFFF_FFEC, 32'd3, -1);
    check("div_m20_3", res, 32'hFFFF_FFFA);
    check("div_m20_3_r", r, 32'hFFFF_FFFE);

    run_op(F3_REM, 32'hFFFF_FFEC, 32'd3, -1);
    check("rem_m20_3", res, 32'hFFFF_FFFE);

    run_op(F3_REM, 32'd20, 32'hFFFF_FFFD, -1);
    check("rem_20_m3", res, 32'd2);
    check("rem_20_m3_q", q, 32'hFFFF_FFFA);

    run_op(F3_DIVU, 32'hFFFF_FFFF, 32'd2, -1);
    check("divu_max_2", res, 32'h7FFF_FFFF);

    run_op(F3_REMU, 32'hFFFF_FFFF, 32'd2, -1);
    check("remu_max_2", res, 32'd1);

    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("ovf_res", res, 32'h8000_0000);
    check("ovf_rem", r, 32'd0);
    check("ovf_lat", 32'(edges), 32'd1);
    check("ovf_stall", 32'(stalls), 32'd1);

    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("ovf_rem_res", res, 32'd0);

    run_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("divu_min_max", res, 32'd0);
    check("divu_min_max_r", r, 32'h8000_0000);
    check("divu_min_lat", 32'(edges), 32'd34);

    run_op(F3_DIV, 32'd123, 32'd0, -1);
    check("div0_res", res, 32'hFFFF_FFFF);
    check("div0_rem", r, 32'd123);
    check("div0_lat", 32'(edges), 32'd1);
    check("div0_stall", 32'(stalls), 32'd1);

    run_op(F3_REMU, 32'd123, 32'd0, -1);
    check("remu0_res", res, 32'd123);
    check("remu0_quo", q, 32'hFFFF_FFFF);

    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd0, -1);
    check("div0_neg_r", r, 32'hFFFF_FFF9);

    run_op(F3_DIV, 32'd20, 32'd3, 5);
    check("poke_res", res, 32'd6);
    check("poke_rem", r, 32'd2);
    check("poke_lat", 32'(edges), 32'd34);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready) pulses++;
    end
    check("poke_pulses", 32'(pulses), 32'd0);
    check("hold_res", bus.result, 32'd6);

    bus.start  = 1'b1;
    bus.funct3 = F3_DIVU;
    bus.A      = 32'd1000000;
    bus.B      = 32'd1000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_cnt", 32'(bus.count_out), 32'd22);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res", bus.result, 32'd0);
    check("arst_quo", bus.quotient, 32'd0);
    check("arst_rem", bus.remainder, 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_cnt", 32'(bus.count_out), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.ready) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.ready) pulses++;
    end
    check("arst_pulses", 32'(pulses), 32'd0);

    run_op(F3_DIVU, 32'd1000000, 32'd1000, -1);
    check("post_rst_res", res, 32'd1000);
    check("post_rst_rem", r, 32'd0);
    check("post_rst_lat", 32'(edges), 32'd34);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
